// File: rtl/calc2_port_responder.sv
// calc2 single-port responder: two-cycle request capture, request FIFO, sequential ALU.
// Optional CALC2_STATS_EN adds saturating ok/err/drop counters.
module calc2_port_responder #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ALU_LATENCY = 3
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req_cmd_in,
  input  logic [31:0] req_data_in,
  input  logic [1:0]  req_tag_in,
  output logic [1:0]  out_resp,
  output logic [31:0] out_data,
  output logic [1:0]  out_tag,
  output logic        drop_err
`ifdef CALC2_STATS_EN
  ,
  output logic [15:0] stat_ok,
  output logic [15:0] stat_err,
  output logic [15:0] stat_drop
`endif
);

  localparam int DATA_W = 32;
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = AW + 1;
  localparam int ENT_W  = 4 + 2 + 2 * DATA_W;
  localparam int CNT_W  = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

  typedef enum logic {CAP_IDLE, CAP_OP2}  cap_state_t;
  typedef enum logic {ALU_FREE, ALU_BUSY} alu_state_t;

  cap_state_t r_cap_state, w_cap_next;
  alu_state_t r_alu_state, w_alu_next;

  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_cap_cmd;
  logic [1:0]        r_cap_tag;
  logic [DATA_W-1:0] r_cap_op1;

  logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count;

  logic [3:0]        r_ex_cmd;
  logic [1:0]        r_ex_tag;
  logic [DATA_W-1:0] r_ex_op1, r_ex_op2;

  logic [1:0]        r_resp;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_tag;
  logic              r_drop;

  logic w_empty, w_full, w_pop, w_wr_req, w_wr, w_drop, w_respond;
  logic [DATA_W+1:0] w_res;

  // Result packed as {resp[1:0], data[31:0]}; data forced to 0 on error.
  function automatic logic [DATA_W+1:0] alu_result(input logic [3:0] cmd,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    alu_result = {2'd2, {DATA_W{1'b0}}};
    sum        = {1'b0, a} + {1'b0, b};
    case (cmd)
      4'd1: if (!sum[DATA_W]) alu_result = {2'd1, sum[DATA_W-1:0]};
      4'd2: if (b <= a)       alu_result = {2'd1, a - b};
      4'd5: alu_result = {2'd1, a << b[4:0]};
      4'd6: alu_result = {2'd1, a >> b[4:0]};
      default: alu_result = {2'd2, {DATA_W{1'b0}}};
    endcase
  endfunction

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_res   = alu_result(r_ex_cmd, r_ex_op1, r_ex_op2);

  always_comb begin
    w_cap_next = r_cap_state;
    w_alu_next = r_alu_state;
    w_wr_req   = 1'b0;
    w_pop      = 1'b0;
    w_respond  = 1'b0;
    if (r_cap_state == CAP_IDLE) begin
      if (req_cmd_in != 4'd0) w_cap_next = CAP_OP2;
    end else begin
      w_wr_req   = 1'b1;
      w_cap_next = CAP_IDLE;
    end
    if (r_alu_state == ALU_FREE) begin
      if (!w_empty) begin
        w_pop      = 1'b1;
        w_alu_next = ALU_BUSY;
      end
    end else if (r_cnt == '0) begin
      w_respond = 1'b1;
      if (!w_empty) w_pop = 1'b1;
      else          w_alu_next = ALU_FREE;
    end
    // A pop in the same cycle frees a slot for a write into a full FIFO.
    w_wr   = w_wr_req & (!w_full | w_pop);
    w_drop = w_wr_req & ~w_wr;
  end

  // Control state, FIFO bookkeeping and registered outputs
  always_ff @(posedge c_clk) begin
    if (reset) begin
      r_cap_state <= CAP_IDLE;
      r_alu_state <= ALU_FREE;
      r_cnt       <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_resp      <= '0;
      r_data      <= '0;
      r_tag       <= '0;
      r_drop      <= 1'b0;
    end else begin
      r_cap_state <= w_cap_next;
      r_alu_state <= w_alu_next;
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop)                                     r_cnt <= CNT_W'(ALU_LATENCY - 1);
      else if (r_alu_state == ALU_BUSY && r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
      if (w_respond) begin
        r_resp <= w_res[DATA_W+1:DATA_W];
        r_data <= w_res[DATA_W-1:0];
        r_tag  <= r_ex_tag;
      end else begin
        r_resp <= '0;
        r_data <= '0;
        r_tag  <= '0;
      end
      r_drop <= w_drop;
    end
  end

  // Datapath registers: capture, FIFO storage, ALU operands
  always_ff @(posedge c_clk) begin
    if (r_cap_state == CAP_IDLE && req_cmd_in != 4'd0) begin
      r_cap_cmd <= req_cmd_in;
      r_cap_tag <= req_tag_in;
      r_cap_op1 <= req_data_in;
    end
    if (w_wr) r_mem[r_wptr] <= {r_cap_cmd, r_cap_tag, r_cap_op1, req_data_in};
    if (w_pop) {r_ex_cmd, r_ex_tag, r_ex_op1, r_ex_op2} <= r_mem[r_rptr];
  end

  assign out_resp = r_resp;
  assign out_data = r_data;
  assign out_tag  = r_tag;
  assign drop_err = r_drop;

`ifdef CALC2_STATS_EN
  logic [15:0] r_stat_ok, r_stat_err, r_stat_drop;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge c_clk) begin
    if (reset) begin
      r_stat_ok   <= '0;
      r_stat_err  <= '0;
      r_stat_drop <= '0;
    end else begin
      if (w_respond && w_res[DATA_W+1:DATA_W] == 2'd1) r_stat_ok  <= sat_inc(r_stat_ok);
      if (w_respond && w_res[DATA_W+1:DATA_W] == 2'd2) r_stat_err <= sat_inc(r_stat_err);
      if (w_drop) r_stat_drop <= sat_inc(r_stat_drop);
    end
  end

  assign stat_ok   = r_stat_ok;
  assign stat_err  = r_stat_err;
  assign stat_drop = r_stat_drop;
`endif

endmodule
